// File: rtl/btn_pkg.sv
// Shared definitions for the button event classifier.
//   btn_state_t       : classifier FSM states (IDLE, PRESSED, REPEAT)
//   BTN_LONG_CYCLES   : default hold time before long_pulse (0.5 s at 100 MHz)
//   BTN_REPEAT_CYCLES : default auto-repeat period (0.1 s at 100 MHz)
//   max_int           : helper for sizing the hold counter
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    REPEAT  = 2'd2
  } btn_state_t;

  localparam int BTN_LONG_CYCLES   = 50_000_000;
  localparam int BTN_REPEAT_CYCLES = 10_000_000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_event.sv
// Button event classifier, one instance per debounced button.
// Turns the debounced level into registered one-cycle strobes.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high reset
//   clean         in   debounced button level, 1 = pressed
//   press_pulse   out  strobe on an accepted press edge
//   click_pulse   out  strobe on a release before the long-press threshold
//   long_pulse    out  strobe when the hold reaches LONG_CYCLES
//   repeat_pulse  out  strobe every REPEAT_CYCLES after long_pulse while held
//   release_pulse out  strobe on every release
//   held          out  level, 1 while the FSM is not IDLE
//   state         out  current FSM state (observation only)
//
// Every output is registered and lags its causing sample by one clock.
// There is no valid/ready handshake: clean is a level sampled every cycle
// and each strobe is valid for exactly the one cycle it is high.
module btn_event
  import btn_pkg::*;
#(
  parameter int LONG_CYCLES   = BTN_LONG_CYCLES,
  parameter int REPEAT_CYCLES = BTN_REPEAT_CYCLES,
  parameter int CNT_W         = $clog2(max_int(LONG_CYCLES, REPEAT_CYCLES))
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clean,
  output logic       press_pulse,
  output logic       click_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       release_pulse,
  output logic       held,
  output btn_state_t state
);

  // Elaboration-time parameter sanity: the counter is compared against
  // max(L,R)-1 and is cleared at each threshold, so it must hold that value.
  generate
    if (LONG_CYCLES < 2) begin : g_bad_long
      $error("btn_event: LONG_CYCLES must be >= 2");
    end
    if (REPEAT_CYCLES < 2) begin : g_bad_repeat
      $error("btn_event: REPEAT_CYCLES must be >= 2");
    end
    if (CNT_W < 1 || (64'(1) << CNT_W) < 64'(max_int(LONG_CYCLES, REPEAT_CYCLES))) begin : g_bad_cnt_w
      $error("btn_event: CNT_W too narrow for max(LONG_CYCLES, REPEAT_CYCLES)-1");
    end
  endgenerate

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  btn_state_t       state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             clean_q;
  logic             press_edge;
  logic             press_n, click_n, long_n, repeat_n, release_n;

  // clean_q resets to 0, so a button already down when reset lifts is seen
  // as a fresh press edge.
  assign press_edge = clean & ~clean_q;
  assign state      = state_q;

  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    press_n   = 1'b0;
    click_n   = 1'b0;
    long_n    = 1'b0;
    repeat_n  = 1'b0;
    release_n = 1'b0;
    case (state_q)
      IDLE: begin
        if (press_edge) begin
          press_n = 1'b1;
          cnt_n   = '0;
          state_n = PRESSED;
        end
      end
      PRESSED: begin
        // Release is tested first so it wins over the long threshold.
        if (!clean) begin
          release_n = 1'b1;
          click_n   = 1'b1;
          cnt_n     = '0;
          state_n   = IDLE;
        end else if (cnt_q == LONG_LAST) begin
          long_n  = 1'b1;
          cnt_n   = '0;
          state_n = REPEAT;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      REPEAT: begin
        if (!clean) begin
          release_n = 1'b1;
          cnt_n     = '0;
          state_n   = IDLE;
        end else if (cnt_q == REPEAT_LAST) begin
          repeat_n = 1'b1;
          cnt_n    = '0;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      clean_q       <= 1'b0;
      press_pulse   <= 1'b0;
      click_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      release_pulse <= 1'b0;
      held          <= 1'b0;
    end else begin
      state_q       <= state_n;
      cnt_q         <= cnt_n;
      clean_q       <= clean;
      press_pulse   <= press_n;
      click_pulse   <= click_n;
      long_pulse    <= long_n;
      repeat_pulse  <= repeat_n;
      release_pulse <= release_n;
      held          <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_btn_event.sv
// Directed bench for btn_event with LONG_CYCLES=8, REPEAT_CYCLES=4.
// Outputs are packed as {press, click, long, repeat, release, held}.
module tb_btn_event;
  import btn_pkg::*;

  localparam int L = 8;
  localparam int R = 4;

  localparam logic [5:0] O_NONE = 6'b000000;
  localparam logic [5:0] O_PRS  = 6'b100000;
  localparam logic [5:0] O_CLK  = 6'b010000;
  localparam logic [5:0] O_LNG  = 6'b001000;
  localparam logic [5:0] O_RPT  = 6'b000100;
  localparam logic [5:0] O_REL  = 6'b000010;
  localparam logic [5:0] O_HLD  = 6'b000001;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic clean;
  logic press_pulse, click_pulse, long_pulse, repeat_pulse, release_pulse, held;
  btn_state_t state;

  always #5 clk = ~clk;

  btn_event #(.LONG_CYCLES(L), .REPEAT_CYCLES(R)) dut (
    .clk           (clk),
    .rst           (rst),
    .clean         (clean),
    .press_pulse   (press_pulse),
    .click_pulse   (click_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse),
    .release_pulse (release_pulse),
    .held          (held),
    .state         (state)
  );

  // ---------------- scoreboard ----------------
  int chk_cnt  = 0;
  int pass_cnt = 0;

  function automatic logic [5:0] outs();
    return {press_pulse, click_pulse, long_pulse, repeat_pulse, release_pulse, held};
  endfunction

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b (press click long repeat release held)", tag, got, exp);
  endtask

  // ---------------- driver ----------------
  // Apply inputs, let one rising edge sample them, then settle 1 time unit
  // so the outputs seen afterwards belong to that edge.
  task automatic tick(input logic c, input logic r);
    clean = c;
    rst   = r;
    @(posedge clk);
    #1;
  endtask

  task automatic step_chk(input logic c, input logic [5:0] exp, input string tag);
    tick(c, 1'b0);
    check(tag, outs(), exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst   = 1'b1;
    clean = 1'b0;
    @(posedge clk);
    #1;
    tick(1'b0, 1'b1);
    check("reset_state", outs(), O_NONE);

    // Idle stability
    for (int i = 0; i < 100; i++) step_chk(1'b0, O_NONE, "idle_stable");

    // Short press: 1 for three edges, then 0
    step_chk(1'b1, O_PRS | O_HLD, "short_press");
    step_chk(1'b1, O_HLD,         "short_held1");
    step_chk(1'b1, O_HLD,         "short_held2");
    step_chk(1'b0, O_CLK | O_REL, "short_click_release");
    step_chk(1'b0, O_NONE,        "short_after");

    // Long hold: 1 for 20 edges t0..t0+19
    step_chk(1'b1, O_PRS | O_HLD, "long_press");
    for (int k = 1; k < 20; k++) begin
      case (k)
        8:       step_chk(1'b1, O_LNG | O_HLD, "long_pulse");
        12, 16:  step_chk(1'b1, O_RPT | O_HLD, "repeat_pulse");
        default: step_chk(1'b1, O_HLD,         "long_held");
      endcase
    end
    step_chk(1'b0, O_REL,  "long_release_no_click");
    step_chk(1'b0, O_NONE, "long_after");

    // Boundary: release sampled exactly at edge t0+8
    step_chk(1'b1, O_PRS | O_HLD, "bnd_press");
    for (int k = 1; k < 8; k++) step_chk(1'b1, O_HLD, "bnd_held");
    step_chk(1'b0, O_CLK | O_REL, "bnd_click_release");
    step_chk(1'b0, O_NONE,        "bnd_no_long");

    // Reset mid-hold at edge t0+10 while clean stays 1
    step_chk(1'b1, O_PRS | O_HLD, "rst_press");
    for (int k = 1; k < 10; k++) step_chk(1'b1, (k == 8) ? (O_LNG | O_HLD) : O_HLD, "rst_hold");
    tick(1'b1, 1'b1);
    check("rst_mid_hold_clear", outs(), O_NONE);
    step_chk(1'b1, O_PRS | O_HLD, "rst_repress");
    step_chk(1'b1, O_HLD,         "rst_held");
    step_chk(1'b0, O_CLK | O_REL, "rst_click_release");
    step_chk(1'b0, O_NONE,        "rst_after");

    // Back-to-back: release at tr, re-press at tr+1
    step_chk(1'b1, O_PRS | O_HLD, "b2b_press1");
    step_chk(1'b1, O_HLD,         "b2b_held1");
    step_chk(1'b1, O_HLD,         "b2b_held2");
    step_chk(1'b0, O_CLK | O_REL, "b2b_release1");
    step_chk(1'b1, O_PRS | O_HLD, "b2b_press2");
    for (int k = 1; k <= 8; k++) step_chk(1'b1, (k == 8) ? (O_LNG | O_HLD) : O_HLD, "b2b_hold2");
    step_chk(1'b1, O_HLD,  "b2b_repeat_gap");
    step_chk(1'b0, O_REL,  "b2b_release2");
    step_chk(1'b0, O_NONE, "b2b_after");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
